// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: cache-line read/write/evict-refill controller to line memory.
// Define MEM_TIMEOUT_EN to abort a stalled access after TIMEOUT_CYC cycles.
module mem_line_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [27:0]  req_addr,
  input  logic [27:0]  req_wb_addr,
  input  logic [127:0] req_wdata,
  output logic         resp_valid,
  output logic [127:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [15:0]  busy_cnt
);

  typedef enum logic [2:0] {IDLE, WR, GAP, RD, DONE} state_t;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_WBRD = 2'b10;

`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_t      state, state_nx;
  logic [1:0]  op_q;
  logic [27:0] addr_q;
  logic        err_q;
  logic [15:0] wait_cnt;
  logic        strobe;
  logic        tmo;

  assign req_ready = (state == IDLE);
  assign strobe    = mem_read || mem_write;

  // Counter restarts whenever the strobe is low, so each phase gets a full budget
  always_ff @(posedge clk) begin
    if (rst || !strobe || mem_ready)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 16'd1;
  end

  assign tmo = TMO_EN && strobe && !mem_ready &&
               (wait_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          unique case (req_op)
            OP_RD:          state_nx = RD;
            OP_WR, OP_WBRD: state_nx = WR;
            default:        state_nx = DONE;
          endcase
        end
      end
      WR: begin
        if (mem_ready)
          state_nx = (op_q == OP_WBRD) ? GAP : DONE;
        else if (tmo)
          state_nx = DONE;
      end
      GAP:  state_nx = RD;
      RD: begin
        if (mem_ready || tmo)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy_cnt   <= '0;
    end else begin
      resp_valid <= (state == DONE);
      resp_err   <= (state == DONE) && err_q;
      if (state != IDLE && busy_cnt != 16'hFFFF)
        busy_cnt <= busy_cnt + 16'd1;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            addr_q    <= req_addr;
            err_q     <= (req_op == 2'b11);
            mem_read  <= (req_op == OP_RD);
            mem_write <= (req_op == OP_WR) || (req_op == OP_WBRD);
            mem_addr  <= (req_op == OP_RD) ? req_addr : req_wb_addr;
            mem_wdata <= req_wdata;
          end
        end
        WR: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
          end else if (tmo) begin
            mem_write <= 1'b0;
            err_q     <= 1'b1;
          end
        end
        GAP: begin
          mem_read <= 1'b1;
          mem_addr <= addr_q;
        end
        RD: begin
          if (mem_ready) begin
            mem_read   <= 1'b0;
            resp_rdata <= mem_rdata;
          end else if (tmo) begin
            mem_read <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb_mem_line_ctrl: table vectors, corner sequences and random transactions
// checked against a transaction-level model of the line controller.
module tb_mem_line_ctrl;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = '0;
  logic [27:0]  req_addr = '0;
  logic [27:0]  req_wb_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         resp_valid;
  logic [127:0] resp_rdata;
  logic         resp_err;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
  logic [15:0]  busy_cnt;

  int checks = 0;
  int errors = 0;
  logic [127:0] model_rdata = '0;
  int model_busy = 0;

  typedef struct {
    logic [1:0]   op;
    logic [27:0]  addr;
    logic [27:0]  wb_addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           wlat;
    int           rlat;
    int           ew;
    int           er;
    int           eg;
    int           elat;
    bit           eerr;
  } vec_t;

  vec_t tbl[$];

  mem_line_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .req_wb_addr(req_wb_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic bit never_ready(input int lat);
`ifdef MEM_TIMEOUT_EN
    return (lat == 0) || (lat > TO);
`else
    return lat == 0;
`endif
  endfunction

  // Transaction-level prediction: phase lengths, gap, latency and error
  function automatic vec_t predict(input vec_t v);
    vec_t o = v;
    bit ab = 1'b0;
    o.ew = 0; o.er = 0; o.eg = 0;
    if (v.op != 2'b11) begin
      if (v.op != 2'b00) begin
        ab   = never_ready(v.wlat);
        o.ew = ab ? TO : v.wlat;
      end
      if (!ab && v.op != 2'b01) begin
        if (v.op == 2'b10) o.eg = 1;
        ab   = never_ready(v.rlat);
        o.er = ab ? TO : v.rlat;
      end
    end
    o.eerr = ab || (v.op == 2'b11);
    o.elat = o.ew + o.eg + o.er + 2;
    return o;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [27:0] a,
                              input logic [27:0] wa, input logic [127:0] wd,
                              input logic [127:0] rd, input int wl,
                              input int rl, input int ew, input int er,
                              input int eg, input int el, input bit ee);
    vec_t v;
    v.op = op; v.addr = a; v.wb_addr = wa; v.wdata = wd; v.rdata = rd;
    v.wlat = wl; v.rlat = rl;
    v.ew = ew; v.er = er; v.eg = eg; v.elat = el; v.eerr = ee;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int w = 0, r = 0, lw = 0, fr = 0, lat = 0, n = 1, gap;
    bit bad = 1'b0, both = 1'b0;
    logic [127:0] got_rd = '0;
    logic got_err = 1'b0, rdy_at_resp = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr;
    req_wb_addr = v.wb_addr; req_wdata = v.wdata;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 28'($urandom);
    req_wb_addr = 28'($urandom);
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    while (lat == 0 && n < 300) begin
      if (mem_write && mem_read) both = 1'b1;
      if (mem_write) begin
        w++; lw = n;
        if (mem_addr !== v.wb_addr || mem_wdata !== v.wdata) bad = 1'b1;
      end
      if (mem_read) begin
        r++;
        if (fr == 0) fr = n;
        if (mem_addr !== v.addr) bad = 1'b1;
      end
      if (resp_valid) begin
        lat = n; got_rd = resp_rdata; got_err = resp_err;
        rdy_at_resp = req_ready;
      end
      mem_ready = (mem_write && w == v.wlat) || (mem_read && r == v.rlat) ||
                  (!mem_write && !mem_read && $urandom_range(0, 1) == 1);
      mem_rdata = mem_read ? v.rdata
                           : {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n++;
    end
    mem_ready = 1'b0;
    if (!v.eerr && (v.op == 2'b00 || v.op == 2'b10)) model_rdata = v.rdata;
    model_busy = model_busy + v.elat - 1;
    if (model_busy > 65535) model_busy = 65535;
    gap = (lw > 0 && fr > 0) ? fr - lw - 1 : 0;
    chk("resp_latency", lat, v.elat);
    chk("write_cycles", w, v.ew);
    chk("read_cycles", r, v.er);
    chk("gap_cycles", gap, v.eg);
    chk("addr_data_stable", bad, 0);
    chk("strobes_exclusive", both, 0);
    chk("resp_err", got_err, v.eerr);
    chk("resp_rdata", got_rd, model_rdata);
    chk("ready_with_resp", rdy_at_resp, 1);
    chk("single_resp_pulse", resp_valid, 0);
    chk("busy_cnt", busy_cnt, model_busy);
  endtask

  initial begin
    int pulses;
    vec_t v;
    repeat (3) @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy_cnt", busy_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    tbl.push_back(mk(2'b00, 28'h0000010, 28'h0, 128'h0,
      128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 0, 4, 0, 4, 0, 6, 0));
    tbl.push_back(mk(2'b01, 28'h0, 28'h0000020, 128'h1234, 128'h0,
      3, 0, 3, 0, 0, 5, 0));
    tbl.push_back(mk(2'b10, 28'h0000007, 28'h0000003, 128'hA5A5_5A5A,
      128'h7777_0000_FFFF_1111, 2, 3, 2, 3, 1, 8, 0));
    tbl.push_back(mk(2'b11, 28'h1, 28'h2, 128'h3, 128'h4,
      1, 1, 0, 0, 0, 2, 1));
    tbl.push_back(mk(2'b00, 28'hFFFFFFF, 28'h0, 128'h0,
      128'h1, 0, 1, 0, 1, 0, 3, 0));
    tbl.push_back(mk(2'b01, 28'h0, 28'hABCDEF0, 128'hFFFF, 128'h0,
      1, 0, 1, 0, 0, 3, 0));
`ifdef MEM_TIMEOUT_EN
    tbl.push_back(mk(2'b00, 28'h0000011, 28'h0, 128'h0, 128'h9,
      0, 0, 0, TO, 0, TO + 2, 1));
    tbl.push_back(mk(2'b10, 28'h0000012, 28'h0000013, 128'h5, 128'h9,
      0, 2, TO, 0, 0, TO + 2, 1));
    tbl.push_back(mk(2'b00, 28'h0000014, 28'h0, 128'h0, 128'hBEEF,
      0, TO, 0, TO, 0, TO + 2, 0));
`endif
    foreach (tbl[i]) run_txn(tbl[i]);

    // reset during the second read cycle
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 28'h0000055;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_mem_read", mem_read, 0);
    chk("midrst_mem_write", mem_write, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_busy_cnt", busy_cnt, 0);
    chk("midrst_rdata", resp_rdata, 0);
    model_busy = 0;
    model_rdata = '0;
    pulses = 0;
    @(negedge clk);
    chk("midrst_ready", req_ready, 1);
    repeat (4) begin
      if (resp_valid) pulses++;
      @(negedge clk);
    end
    chk("midrst_no_resp", pulses, 0);

    for (int k = 0; k < 40; k++) begin
      v.op = 2'($urandom_range(0, 3));
      v.addr = 28'($urandom);
      v.wb_addr = 28'($urandom);
      v.wdata = {$urandom, $urandom, $urandom, $urandom};
      v.rdata = {$urandom, $urandom, $urandom, $urandom};
`ifdef MEM_TIMEOUT_EN
      v.wlat = $urandom_range(0, 10);
      v.rlat = $urandom_range(0, 10);
`else
      v.wlat = $urandom_range(1, 6);
      v.rlat = $urandom_range(1, 6);
`endif
      run_txn(predict(v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
